// File: rtl/pkt_head_update_dispatcher_if.sv
// Head-update dispatcher bus: MMIO head writes in, heads-table writes and
// descriptor-only notifications out.
//   in_head_wr_*   : valid/ready head update from the register decoder
//   head_tbl_wr_*  : one-cycle write strobe into the queue heads table
//   out_meta_*     : valid/ready notification towards the queue manager
// modport slave  : dispatcher side
// modport master : requester / environment side
interface pkt_head_update_dispatcher_if #(
    parameter int NB_QUEUES = 512,
    parameter int PTR_WIDTH = 16
);
    localparam int QUEUE_ID_WIDTH = $clog2(NB_QUEUES);

    logic                      in_head_wr_valid;
    logic                      in_head_wr_ready;
    logic [QUEUE_ID_WIDTH-1:0] in_head_wr_queue_id;
    logic [PTR_WIDTH-1:0]      in_head_wr_ptr;

    logic                      head_tbl_wr_en;
    logic [QUEUE_ID_WIDTH-1:0] head_tbl_wr_addr;
    logic [PTR_WIDTH-1:0]      head_tbl_wr_data;

    logic                      out_meta_valid;
    logic                      out_meta_ready;
    logic [QUEUE_ID_WIDTH-1:0] out_meta_queue_id;
    logic [PTR_WIDTH-1:0]      out_meta_head;

    modport slave (
        input  in_head_wr_valid,
        output in_head_wr_ready,
        input  in_head_wr_queue_id,
        input  in_head_wr_ptr,
        output head_tbl_wr_en,
        output head_tbl_wr_addr,
        output head_tbl_wr_data,
        output out_meta_valid,
        input  out_meta_ready,
        output out_meta_queue_id,
        output out_meta_head
    );

    modport master (
        output in_head_wr_valid,
        input  in_head_wr_ready,
        output in_head_wr_queue_id,
        output in_head_wr_ptr,
        input  head_tbl_wr_en,
        input  head_tbl_wr_addr,
        input  head_tbl_wr_data,
        input  out_meta_valid,
        output out_meta_ready,
        input  out_meta_queue_id,
        input  out_meta_head
    );
endinterface

// File: rtl/pkt_head_update_dispatcher.sv
// Packet-queue head-update dispatcher: records every software head write in
// the heads table and emits at most one pending notification per queue,
// always carrying the newest head written for that queue.
// Ports:
//   clk, rst        : clock, asynchronous active-low reset
//   bus (slave)     : in_head_wr_*, head_tbl_wr_*, out_meta_* handshakes
//   update_cnt      : accepted updates (saturating)
//   coalesced_cnt   : updates merged into an already pending notification
// Define PKT_HEAD_STATS_EN to implement the two counters; otherwise they
// read as zero and their flops are not built.
module pkt_head_update_dispatcher #(
    parameter int NB_QUEUES      = 512,
    parameter int PTR_WIDTH      = 16,
    parameter int QUEUE_ID_WIDTH = $clog2(NB_QUEUES)
) (
    input  logic                             clk,
    input  logic                             rst,
    pkt_head_update_dispatcher_if.slave      bus,
    output logic [31:0]                      update_cnt,
    output logic [31:0]                      coalesced_cnt
);
    localparam int QW = QUEUE_ID_WIDTH;

    typedef logic [QW-1:0]        qid_t;
    typedef logic [PTR_WIDTH-1:0] ptr_t;

    // Storage without reset: contents are only read after being written.
    ptr_t head_mem [NB_QUEUES];
    qid_t fifo_mem [NB_QUEUES];

    logic [NB_QUEUES-1:0] pend_q, pend_d;
    qid_t                 rd_ptr_q, wr_ptr_q;
    logic [QW:0]          cnt_q, cnt_d;

    logic out_valid_q;
    qid_t out_qid_q;
    ptr_t out_head_q;

    logic tbl_en_q;
    qid_t tbl_addr_q;
    ptr_t tbl_data_q;

    logic acc, hit, push, pop, bypass;
    qid_t acc_qid, pop_qid;
    ptr_t acc_ptr, pop_head;

    // Pending bitmap caps the FIFO at NB_QUEUES entries, so no backpressure.
    assign bus.in_head_wr_ready = rst;

    assign acc     = bus.in_head_wr_valid & rst;
    assign acc_qid = bus.in_head_wr_queue_id;
    assign acc_ptr = bus.in_head_wr_ptr;
    assign hit     = pend_q[acc_qid];
    assign push    = acc & ~hit;

    assign pop     = (cnt_q != '0) & (~out_valid_q | bus.out_meta_ready);
    assign pop_qid = fifo_mem[rd_ptr_q];

    // A write to the queue being popped is newer than the stored head.
    assign bypass   = pop & acc & (acc_qid == pop_qid);
    assign pop_head = bypass ? acc_ptr : head_mem[pop_qid];

    // A pushed queue is never the popped one: the popped queue is pending.
    always_comb begin
        pend_d = pend_q;
        if (pop)  pend_d[pop_qid] = 1'b0;
        if (push) pend_d[acc_qid] = 1'b1;
    end

    always_comb begin
        cnt_d = cnt_q;
        if (push && !pop)      cnt_d = cnt_q + (QW+1)'(1);
        else if (!push && pop) cnt_d = cnt_q - (QW+1)'(1);
    end

    always_ff @(posedge clk) begin
        if (acc)  head_mem[acc_qid] <= acc_ptr;
        if (push) fifo_mem[wr_ptr_q] <= acc_qid;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_q      <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_qid_q   <= '0;
            out_head_q  <= '0;
            tbl_en_q    <= 1'b0;
            tbl_addr_q  <= '0;
            tbl_data_q  <= '0;
        end else begin
            pend_q   <= pend_d;
            cnt_q    <= cnt_d;
            tbl_en_q <= acc;
            if (acc) begin
                tbl_addr_q <= acc_qid;
                tbl_data_q <= acc_ptr;
            end
            if (push) wr_ptr_q <= wr_ptr_q + QW'(1);
            if (pop) begin
                rd_ptr_q    <= rd_ptr_q + QW'(1);
                out_valid_q <= 1'b1;
                out_qid_q   <= pop_qid;
                out_head_q  <= pop_head;
            end else if (bus.out_meta_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.head_tbl_wr_en    = tbl_en_q;
    assign bus.head_tbl_wr_addr  = tbl_addr_q;
    assign bus.head_tbl_wr_data  = tbl_data_q;
    assign bus.out_meta_valid    = out_valid_q;
    assign bus.out_meta_queue_id = out_qid_q;
    assign bus.out_meta_head     = out_head_q;

`ifdef PKT_HEAD_STATS_EN
    logic [31:0] upd_q, coal_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            upd_q  <= '0;
            coal_q <= '0;
        end else begin
            if (acc && upd_q != '1)        upd_q  <= upd_q + 32'd1;
            if (acc && hit && coal_q != '1) coal_q <= coal_q + 32'd1;
        end
    end

    assign update_cnt    = upd_q;
    assign coalesced_cnt = coal_q;
`else
    assign update_cnt    = '0;
    assign coalesced_cnt = '0;
`endif

endmodule
